// File: rtl/divider_special_pkg.sv
// Shared types and magnitude constants for the divider special-case path.
package divider_special_pkg;

   // Widest E+M supported by the magnitude constant functions.
   localparam int MAG_MAX_W = 128;

   // Class of a single operand, decided from its magnitude only.
   typedef enum logic [1:0] {
      NONE,
      INF,
      ZERO,
      ONE
   } op_class_e;

   // Sign-independent kind of the resolved result for an operand pair.
   typedef enum logic [2:0] {
      RK_NONE,
      RK_INVALID,
      RK_DIV0,
      RK_INF,
      RK_ZERO,
      RK_PASS_X
   } result_kind_e;

   // All ones in the low e+m bits: the infinity magnitude.
   function automatic logic [MAG_MAX_W-1:0] inf_mag(input int e, input int m);
      logic [MAG_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < MAG_MAX_W; i++) begin
         if (i < e + m) r[i] = 1'b1;
      end
      return r;
   endfunction

   // All zeros in the low e+m bits: the zero magnitude.
   function automatic logic [MAG_MAX_W-1:0] zero_mag(input int e, input int m);
      logic [MAG_MAX_W-1:0] r;
      r = inf_mag(e, m);
      for (int i = 0; i < MAG_MAX_W; i++) begin
         if (i < e + m) r[i] = 1'b0;
      end
      return r;
   endfunction

   // Exponent {1,0..0} with zero mantissa: the magnitude of one.
   function automatic logic [MAG_MAX_W-1:0] one_mag(input int e, input int m);
      logic [MAG_MAX_W-1:0] r;
      r = '0;
      r[e + m - 1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/special_case_classifier.sv
// Combinational operand classifier: splits an operand into sign and class.
module special_case_classifier
   import divider_special_pkg::*;
#(
   parameter int M = 23,
   parameter int E = 8
) (
   input  logic [E+M:0] op_i,
   output op_class_e    cls_o,
   output logic         sign_o
);

   localparam logic [MAG_MAX_W-1:0] INF_FULL  = inf_mag(E, M);
   localparam logic [MAG_MAX_W-1:0] ZERO_FULL = zero_mag(E, M);
   localparam logic [MAG_MAX_W-1:0] ONE_FULL  = one_mag(E, M);
   localparam logic [E+M-1:0]       INF_MAG   = INF_FULL[E+M-1:0];
   localparam logic [E+M-1:0]       ZERO_MAG  = ZERO_FULL[E+M-1:0];
   localparam logic [E+M-1:0]       ONE_MAG   = ONE_FULL[E+M-1:0];

   logic [E+M-1:0] mag;

   assign mag    = op_i[E+M-1:0];
   assign sign_o = op_i[E+M];

   // Class is decided purely from the magnitude bits.
   always_comb begin
      cls_o = NONE;
      if (mag == INF_MAG)       cls_o = INF;
      else if (mag == ZERO_MAG) cls_o = ZERO;
      else if (mag == ONE_MAG)  cls_o = ONE;
   end

endmodule

// File: rtl/special_result_pipe.sv
// Special-case resolver for the HUB divider, delayed to match the core latency.
module special_result_pipe
   import divider_special_pkg::*;
#(
   parameter int M     = 23,
   parameter int E     = 8,
   parameter int LAT   = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [E+M:0]     X,
   input  logic [E+M:0]     Y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [E+M:0]     special_result,
   output logic             is_special,
   output logic             flag_invalid,
   output logic             flag_div0,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] special_cnt
);

   localparam int W = E + M + 1;
   localparam logic [MAG_MAX_W-1:0] INF_FULL  = inf_mag(E, M);
   localparam logic [MAG_MAX_W-1:0] ZERO_FULL = zero_mag(E, M);
   localparam logic [E+M-1:0]       INF_MAG   = INF_FULL[E+M-1:0];
   localparam logic [E+M-1:0]       ZERO_MAG  = ZERO_FULL[E+M-1:0];

   op_class_e       x_cls, y_cls;
   logic            x_sgn, y_sgn, s;
   result_kind_e    kind;
   logic            advance, accept;
   logic [W-1:0]    res_d;
   logic            sp_d, inv_d, dz_d;
   logic [LAT-1:0]  vld_q, sp_q, inv_q, dz_q;
   logic [W-1:0]    res_q [LAT];
   logic [CNT_W-1:0] cnt_d, cnt_q;

   special_case_classifier #(.M(M), .E(E)) u_cls_x (
      .op_i   (X),
      .cls_o  (x_cls),
      .sign_o (x_sgn)
   );

   special_case_classifier #(.M(M), .E(E)) u_cls_y (
      .op_i   (Y),
      .cls_o  (y_cls),
      .sign_o (y_sgn)
   );

   assign s        = x_sgn ^ y_sgn;
   assign advance  = !vld_q[LAT-1] || out_ready;
   assign in_ready = advance;
   assign accept   = in_valid && advance;

   // Priority resolution of the operand-class pair; first match wins.
   always_comb begin
      kind = RK_NONE;
      if ((x_cls == ZERO && y_cls == ZERO) || (x_cls == INF && y_cls == INF)) kind = RK_INVALID;
      else if (y_cls == ZERO) kind = RK_DIV0;
      else if (x_cls == ZERO) kind = RK_ZERO;
      else if (y_cls == INF)  kind = RK_ZERO;
      else if (x_cls == INF)  kind = RK_INF;
      else if (y_cls == ONE)  kind = RK_PASS_X;
   end

   // Map the result kind onto the signed result word and flags.
   always_comb begin
      res_d = '0;
      sp_d  = 1'b1;
      inv_d = 1'b0;
      dz_d  = 1'b0;
      case (kind)
         RK_INVALID: begin res_d = {1'b1, INF_MAG}; inv_d = 1'b1; end
         RK_DIV0:    begin res_d = {s, INF_MAG};    dz_d  = 1'b1; end
         RK_INF:     res_d = {s, INF_MAG};
         RK_ZERO:    res_d = {s, ZERO_MAG};
         RK_PASS_X:  res_d = {s, X[E+M-1:0]};
         default:    sp_d  = 1'b0;
      endcase
   end

   // Stage valid bits: shift on advance, an idle input becomes an empty slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
      end else if (advance) begin
         vld_q[0] <= in_valid;
         for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   // Stage payload: shifts with the valid bits, meaningless in empty slots.
   always_ff @(posedge clk) begin
      if (advance) begin
         res_q[0] <= res_d;
         sp_q[0]  <= sp_d;
         inv_q[0] <= inv_d;
         dz_q[0]  <= dz_d;
         for (int i = 1; i < LAT; i++) begin
            res_q[i] <= res_q[i-1];
            sp_q[i]  <= sp_q[i-1];
            inv_q[i] <= inv_q[i-1];
            dz_q[i]  <= dz_q[i-1];
         end
      end
   end

   // Output fields read zero whenever the last stage holds no pair.
   assign out_valid      = vld_q[LAT-1];
   assign special_result = vld_q[LAT-1] ? res_q[LAT-1] : '0;
   assign is_special     = vld_q[LAT-1] & sp_q[LAT-1];
   assign flag_invalid   = vld_q[LAT-1] & inv_q[LAT-1];
   assign flag_div0      = vld_q[LAT-1] & dz_q[LAT-1];

   // Saturating special-pair counter; clear beats a same-cycle increment.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr)                                cnt_d = '0;
      else if (accept && sp_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign special_cnt = cnt_q;

endmodule

// File: tb/tb_special_result_pipe.sv
// Directed bench for special_result_pipe (default geometry plus a 2-bit counter copy).
module tb_special_result_pipe;

   localparam int M   = 23;
   localparam int E   = 8;
   localparam int LAT = 4;
   localparam int W   = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, in_valid, in_ready, out_valid, out_ready;
   logic         is_special, flag_invalid, flag_div0, cnt_clr;
   logic [W-1:0] X, Y, special_result;
   logic [15:0]  special_cnt;

   logic         in_valid2, in_ready2, out_valid2, is_special2, flag_invalid2, flag_div02, cnt_clr2;
   logic [W-1:0] X2, Y2, res2;
   logic [1:0]   cnt2;

   int checks = 0;
   int errors = 0;

   special_result_pipe #(.M(M), .E(E), .LAT(LAT), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
      .special_result(special_result), .is_special(is_special),
      .flag_invalid(flag_invalid), .flag_div0(flag_div0),
      .cnt_clr(cnt_clr), .special_cnt(special_cnt)
   );

   special_result_pipe #(.M(M), .E(E), .LAT(2), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .X(X2), .Y(Y2), .out_valid(out_valid2), .out_ready(1'b1),
      .special_result(res2), .is_special(is_special2),
      .flag_invalid(flag_invalid2), .flag_div0(flag_div02),
      .cnt_clr(cnt_clr2), .special_cnt(cnt2)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One pair through an otherwise empty pipe, checked at exactly LAT cycles.
   task automatic send_one(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp_r, input logic exp_sp,
                           input logic exp_inv, input logic exp_dz);
      X = x; Y = y; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int k = 1; k < LAT; k++) begin
         check({tag, "_early"}, out_valid, 0);
         step();
      end
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_result"}, special_result, exp_r);
      check({tag, "_special"}, is_special, exp_sp);
      check({tag, "_invalid"}, flag_invalid, exp_inv);
      check({tag, "_div0"}, flag_div0, exp_dz);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   logic [3:0]  pat = 4'b1001;
   int          sent, recv, seen;
   logic        stalled;
   logic [31:0] held;

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; X = '0; Y = '0; cnt_clr = 1'b0;
      in_valid2 = 1'b0; X2 = '0; Y2 = '0; cnt_clr2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_out_valid", out_valid, 0);
      check("reset_in_ready", in_ready, 1);
      check("reset_result", special_result, 0);
      check("reset_flags", {is_special, flag_invalid, flag_div0}, 0);
      check("reset_cnt", special_cnt, 0);

      send_one("zero_zero", 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1, 1, 0);
      send_one("div0",      32'h40400000, 32'h80000000, 32'hFFFFFFFF, 1, 0, 1);
      send_one("xinf",      32'hFFFFFFFF, 32'h40400000, 32'hFFFFFFFF, 1, 0, 0);
      send_one("yone",      32'hC0A00000, 32'hC0000000, 32'h40A00000, 1, 0, 0);
      send_one("ordinary",  32'h40400000, 32'h40A00000, 32'h00000000, 0, 0, 0);
      send_one("inf_inf",   32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 0);
      send_one("xzero",     32'h80000000, 32'h40400000, 32'h80000000, 1, 0, 0);
      send_one("yinf",      32'h40400000, 32'h7FFFFFFF, 32'h00000000, 1, 0, 0);
      send_one("zero_inf",  32'h00000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 0);
      send_one("inf_one",   32'h7FFFFFFF, 32'h40000000, 32'h7FFFFFFF, 1, 0, 0);
      check("cnt_after_directed", special_cnt, 9);

      // Back-to-back stream under a 1,0,0,1 out_ready pattern.
      sent = 0; recv = 0; stalled = 1'b0; held = '0;
      for (int cyc = 0; cyc < 200 && recv < 10; cyc++) begin
         out_ready = pat[cyc % 4];
         in_valid  = (sent < 10);
         X = 32'h40800000 + sent;
         Y = 32'h40000000;
         #1;
         if (stalled) begin
            check("stall_hold_valid", out_valid, 1);
            check("stall_hold_data", special_result, held);
         end
         stalled = out_valid && !out_ready;
         held    = special_result;
         if (stalled) check("stall_in_ready", in_ready, 0);
         if (out_valid && out_ready) begin
            check("stream_order", special_result, 32'h40800000 + recv);
            recv++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         #1;
      end
      check("stream_count", recv, 10);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (LAT + 1) step();
      check("stream_no_dup", out_valid, 0);

      // Reset with three pairs in flight.
      X = 32'h40400000; Y = 32'h80000000; in_valid = 1'b1;
      repeat (3) step();
      in_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      check("midrst_result", special_result, 0);
      check("midrst_cnt", special_cnt, 0);
      seen = 0;
      repeat (LAT + 3) begin
         step();
         if (out_valid) seen++;
      end
      check("midrst_no_stale", seen, 0);

      // 2-bit counter saturation and clear priority.
      X2 = 32'h00000000; Y2 = 32'h80000000; in_valid2 = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         check("cnt2_sat", cnt2, (k < 3) ? k : 3);
         check("cnt2_in_ready", in_ready2, 1);
         if (k >= 2) begin
            check("cnt2_out_valid", out_valid2, 1);
            check("cnt2_result", res2, 32'hFFFFFFFF);
            check("cnt2_flags", {is_special2, flag_invalid2, flag_div02}, 3'b110);
         end
      end
      cnt_clr2 = 1'b1;
      step();
      cnt_clr2 = 1'b0;
      check("cnt2_clr_priority", cnt2, 0);
      step();
      X2 = 32'h40400000; Y2 = 32'h40A00000;
      check("cnt2_after_clr", cnt2, 1);
      step();
      in_valid2 = 1'b0;
      check("cnt2_ordinary_no_inc", cnt2, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
